// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the multi-cycle controller: default bus widths,
// opcode encodings, the sequencer state enum and the decoded opcode class.
// No ports.
package cpu_pkg;

  localparam int CPU_ADDR_WIDTH = 32;
  localparam int CPU_DATA_WIDTH = 32;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT,
    S_TRAP
  } state_e;

  // One-hot opcode class; all zero means the opcode is illegal.
  typedef struct packed {
    logic is_reg;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_halt;
  } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Instruction- and data-memory handshake bundle.
//   imem_req/imem_addr   controller -> imem   fetch request and address
//   imem_ready/imem_rdata imem -> controller  fetched word valid
//   dmem_req/dmem_we     controller -> dmem   data access, store when we=1
//   dmem_ready           dmem -> controller   data access complete
// master: controller side, slave: memory side.
interface multicycle_controller_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = CPU_DATA_WIDTH
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  dmem_req;
  logic                  dmem_we;
  logic                  dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_controller_opcode_decoder.sv
// opcode_decoder
// Combinational opcode classifier.
//   opcode_i   in   instruction[6:0]
//   class_o    out  one-hot opcode class
//   illegal_o  out  opcode matches no known class
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o           = '0;
    class_o.is_reg    = (opcode_i == OP_REG);
    class_o.is_imm    = (opcode_i == OP_IMM);
    class_o.is_load   = (opcode_i == OP_LOAD);
    class_o.is_store  = (opcode_i == OP_STORE);
    class_o.is_branch = (opcode_i == OP_BRANCH);
    class_o.is_halt   = (opcode_i == OP_HALT);
  end

  assign illegal_o = (class_o == '0);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multi-cycle sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback; owns PC, instruction register and the
// retired-instruction counter.
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, boot_addr      leave IDLE and fetch from boot_addr
//   mem                   imem/dmem handshake (master modport)
//   instruction           latched instruction register
//   regfile_read_en/write_en, alu_en   datapath strobes
//   branch_taken/target   ALU branch result, sampled in EXECUTE
//   pc, halted, trap, retired          status
//
// state     | meaning
// S_IDLE    | waiting for start, all strobes low
// S_FETCH   | imem_req until imem_ready, latch instruction
// S_DECODE  | read source registers, classify opcode
// S_EXECUTE | ALU cycle, branches resolve here
// S_MEM     | dmem_req until dmem_ready
// S_WRITEBACK | write rd (unless x0), advance pc
// S_HALT    | HALT executed, frozen until reset
// S_TRAP    | illegal opcode, frozen until reset
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  multicycle_controller_if.master mem,
  output logic [DATA_WIDTH-1:0]  instruction,
  output logic                   regfile_read_en,
  output logic                   regfile_write_en,
  output logic                   alu_en,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted,
  output logic                   trap,
  output logic [31:0]            retired
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [31:0]           retired_q, retired_d;
  op_class_t             op_class;
  logic                  op_illegal;
  logic [ADDR_WIDTH-1:0] pc_next_seq;

  opcode_decoder u_opcode_decoder (
    .opcode_i  (ir_q[6:0]),
    .class_o   (op_class),
    .illegal_o (op_illegal)
  );

  // Wraps modulo 2^ADDR_WIDTH by truncation.
  assign pc_next_seq = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = boot_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem.imem_ready) begin
          ir_d    = mem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_illegal)           state_d = S_TRAP;
        else if (op_class.is_halt) state_d = S_HALT;
        else                      state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (op_class.is_reg || op_class.is_imm) begin
          state_d = S_WRITEBACK;
        end else if (op_class.is_load || op_class.is_store) begin
          state_d = S_MEM;
        end else begin
          pc_d      = branch_taken ? branch_target : pc_next_seq;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem.dmem_ready) begin
          if (op_class.is_store) begin
            pc_d      = pc_next_seq;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        pc_d      = pc_next_seq;
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Moore outputs: decoded from registered state only.
  assign mem.imem_req     = (state_q == S_FETCH);
  assign mem.imem_addr    = pc_q;
  assign mem.dmem_req     = (state_q == S_MEM);
  assign mem.dmem_we      = (state_q == S_MEM) && op_class.is_store;
  assign regfile_read_en  = (state_q == S_DECODE);
  assign alu_en           = (state_q == S_EXECUTE);
  assign regfile_write_en = (state_q == S_WRITEBACK) && (ir_q[11:7] != 5'd0);
  assign halted           = (state_q == S_HALT);
  assign trap             = (state_q == S_TRAP);
  assign instruction      = ir_q;
  assign pc               = pc_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] boot_addr = 32'h0;
  logic [31:0] instruction;
  logic        regfile_read_en, regfile_write_en, alu_en;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc;
  logic        halted, trap;
  logic [31:0] retired;

  int total = 0;
  int bad = 0;
  int imem_wait = 0;
  int dmem_wait = 0;
  int ic = 0;
  int dc = 0;

  always #5 clock = ~clock;

  multicycle_controller_if mif ();

  multicycle_controller dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .boot_addr        (boot_addr),
    .mem              (mif),
    .instruction      (instruction),
    .regfile_read_en  (regfile_read_en),
    .regfile_write_en (regfile_write_en),
    .alu_en           (alu_en),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .pc               (pc),
    .halted           (halted),
    .trap             (trap),
    .retired          (retired)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00208233;  // add x4,x1,x2
      32'h200: return 32'h00000063;  // beq
      32'h040: return 32'h00000063;
      32'h400: return 32'h00002003;  // lw x0
      32'h404: return 32'h00112023;  // sw
      32'h500: return 32'h00208233;
      32'h504: return 32'h0000007F;  // halt
      32'h600: return 32'h00000000;  // illegal
      default: return 32'h00000013;
    endcase
  endfunction

  // Memory responder: ready after imem_wait/dmem_wait stalled request cycles.
  initial begin
    mif.imem_ready = 1'b0;
    mif.imem_rdata = 32'h0;
    mif.dmem_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (mif.imem_req) begin
        if (ic >= imem_wait) begin
          mif.imem_ready = 1'b1;
          mif.imem_rdata = imem_word(mif.imem_addr);
          ic = 0;
        end else begin
          mif.imem_ready = 1'b0;
          mif.imem_rdata = 32'hDEADBEEF;
          ic++;
        end
      end else begin
        mif.imem_ready = 1'b0;
        ic = 0;
      end
      if (mif.dmem_req) begin
        if (dc >= dmem_wait) begin
          mif.dmem_ready = 1'b1;
          dc = 0;
        end else begin
          mif.dmem_ready = 1'b0;
          dc++;
        end
      end else begin
        mif.dmem_ready = 1'b0;
        dc = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic boot(input logic [31:0] a);
    boot_addr = a;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Starting in FETCH, step until the next FETCH begins and record what was seen.
  task automatic run_instr(input logic [31:0] ir_before, output int ncyc,
                           output int rfwe_at, output int rfwe_n, output int ireq_n,
                           output int dreq_n, output int dwe_n, output logic ir_early);
    logic prev;
    ncyc = -1; rfwe_at = 0; rfwe_n = 0; ireq_n = 0; dreq_n = 0; dwe_n = 0; ir_early = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (regfile_write_en) begin
        rfwe_n++;
        if (rfwe_at == 0) rfwe_at = n;
      end
      if (mif.imem_req) begin
        ireq_n++;
        if (instruction !== ir_before) ir_early = 1'b1;
      end
      if (mif.dmem_req) dreq_n++;
      if (mif.dmem_we) dwe_n++;
      prev = mif.imem_req;
      tick;
      if (mif.imem_req && !prev) begin
        ncyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_ir got=%0h want=0", instruction); end
    total++; if (retired !== 32'h0) begin bad++; $display("FAIL reset_retired got=%0h want=0", retired); end
    tick; tick;
    total++;
    if ({mif.imem_req, mif.dmem_req, mif.dmem_we, regfile_read_en, regfile_write_en, alu_en, halted, trap} !== 8'h0) begin
      bad++; $display("FAIL reset_strobes got=%b want=00000000",
        {mif.imem_req, mif.dmem_req, mif.dmem_we, regfile_read_en, regfile_write_en, alu_en, halted, trap});
    end
  endtask

  task automatic test_reg_zero_wait;
    int n, wa, wn, irn, drn, dwn; logic early;
    imem_wait = 0;
    boot(32'h100);
    total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h100) begin
      bad++; $display("FAIL reg_fetch got req=%b addr=%0h want req=1 addr=100", mif.imem_req, mif.imem_addr); end
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    total++; if (n !== 4) begin bad++; $display("FAIL reg_cycles got=%0d want=4", n); end
    total++; if (wa !== 4 || wn !== 1) begin bad++; $display("FAIL reg_wb got at=%0d cnt=%0d want at=4 cnt=1", wa, wn); end
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL reg_pc got=%0h want=104", pc); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL reg_retired got=%0d want=1", retired); end
    total++; if (instruction !== 32'h00208233) begin bad++; $display("FAIL reg_ir got=%0h want=00208233", instruction); end
  endtask

  task automatic test_fetch_wait;
    int n, wa, wn, irn, drn, dwn; logic early;
    do_reset;
    imem_wait = 3;
    boot(32'h100);
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    imem_wait = 0;
    total++; if (n !== 7) begin bad++; $display("FAIL wait_cycles got=%0d want=7", n); end
    total++; if (irn !== 4) begin bad++; $display("FAIL wait_req_len got=%0d want=4", irn); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL wait_ir_early got=%b want=0", early); end
    total++; if (instruction !== 32'h00208233) begin bad++; $display("FAIL wait_ir got=%0h want=00208233", instruction); end
    total++; if (pc !== 32'h104 || retired !== 32'd1) begin
      bad++; $display("FAIL wait_pc_ret got pc=%0h ret=%0d want pc=104 ret=1", pc, retired); end
  endtask

  task automatic test_load_store;
    int n, wa, wn, irn, drn, dwn; logic early;
    do_reset;
    dmem_wait = 2;
    boot(32'h400);
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    total++; if (n !== 7) begin bad++; $display("FAIL load_cycles got=%0d want=7", n); end
    total++; if (wn !== 0) begin bad++; $display("FAIL load_rd0_write got=%0d want=0", wn); end
    total++; if (drn !== 3 || dwn !== 0) begin bad++; $display("FAIL load_dmem got req=%0d we=%0d want req=3 we=0", drn, dwn); end
    run_instr(32'h00002003, n, wa, wn, irn, drn, dwn, early);
    total++; if (n !== 6) begin bad++; $display("FAIL store_cycles got=%0d want=6", n); end
    total++; if (drn !== 3 || dwn !== 3 || wn !== 0) begin
      bad++; $display("FAIL store_dmem got req=%0d we=%0d rfwe=%0d want 3 3 0", drn, dwn, wn); end
    total++; if (retired !== 32'd2 || pc !== 32'h408) begin
      bad++; $display("FAIL ldst_final got ret=%0d pc=%0h want ret=2 pc=408", retired, pc); end
    dmem_wait = 0;
  endtask

  task automatic test_branch;
    int n, wa, wn, irn, drn, dwn; logic early;
    do_reset;
    branch_taken = 1'b1;
    branch_target = 32'h040;
    boot(32'h200);
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    total++; if (n !== 3) begin bad++; $display("FAIL br_cycles got=%0d want=3", n); end
    total++; if (mif.imem_addr !== 32'h040) begin bad++; $display("FAIL br_taken got=%0h want=40", mif.imem_addr); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL br_retired got=%0d want=1", retired); end
    do_reset;
    branch_taken = 1'b0;
    boot(32'h200);
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    total++; if (mif.imem_addr !== 32'h204) begin bad++; $display("FAIL br_not_taken got=%0h want=204", mif.imem_addr); end
    branch_target = 32'h0;
  endtask

  task automatic test_halt_trap;
    int n, wa, wn, irn, drn, dwn, viol; logic early;
    do_reset;
    boot(32'h500);
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    for (int i = 0; i < 10 && !halted; i++) tick;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_reached got=%b want=1", halted); end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || trap !== 1'b0 || pc !== 32'h504 || retired !== 32'd1 ||
          {mif.imem_req, mif.dmem_req, regfile_read_en, regfile_write_en, alu_en} !== 5'h0) viol++;
      tick;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL halt_sticky got=%0d bad cycles want=0", viol); end
    total++; if (instruction !== 32'h7F) begin bad++; $display("FAIL halt_ir got=%0h want=7f", instruction); end
    do_reset;
    boot(32'h600);
    for (int i = 0; i < 10 && !trap; i++) tick;
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL trap_reached got=%b want=1", trap); end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (trap !== 1'b1 || halted !== 1'b0 || pc !== 32'h600 || retired !== 32'd0 ||
          {mif.imem_req, mif.dmem_req, regfile_read_en, regfile_write_en, alu_en} !== 5'h0) viol++;
      tick;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL trap_sticky got=%0d bad cycles want=0", viol); end
  endtask

  task automatic test_reset_mid_mem;
    int n, wa, wn, irn, drn, dwn; logic early;
    do_reset;
    dmem_wait = 5;
    boot(32'h400);
    for (int i = 0; i < 10 && !mif.dmem_req; i++) tick;
    tick;
    total++; if (mif.dmem_req !== 1'b1) begin bad++; $display("FAIL midmem_setup got=%b want=1", mif.dmem_req); end
    reset = 1'b1;
    tick;
    total++;
    if ({mif.imem_req, mif.dmem_req, regfile_read_en, regfile_write_en, alu_en, halted, trap} !== 7'h0 ||
        pc !== 32'h0 || instruction !== 32'h0 || retired !== 32'h0) begin
      bad++; $display("FAIL midmem_idle got dreq=%b pc=%0h ir=%0h want idle zeros", mif.dmem_req, pc, instruction);
    end
    reset = 1'b0;
    dmem_wait = 0;
    boot(32'h100);
    total++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h100) begin
      bad++; $display("FAIL midmem_restart got req=%b addr=%0h want 1 100", mif.imem_req, mif.imem_addr); end
    run_instr(32'h0, n, wa, wn, irn, drn, dwn, early);
    total++; if (pc !== 32'h104 || retired !== 32'd1) begin
      bad++; $display("FAIL midmem_run got pc=%0h ret=%0d want 104 1", pc, retired); end
  endtask

  task automatic test_retired_wrap;
    do_reset;
    boot(32'h100);
    tick;
    force dut.retired_q = 32'hFFFFFFFF;
    tick;
    release dut.retired_q;
    total++; if (retired !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_preload got=%0h want=ffffffff", retired); end
    tick;
    tick;
    total++; if (retired !== 32'h0) begin bad++; $display("FAIL wrap_retired got=%0h want=0", retired); end
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL wrap_pc got=%0h want=104", pc); end
  endtask

  initial begin
    test_reset;
    test_reg_zero_wait;
    test_fetch_wait;
    test_load_store;
    test_branch;
    test_halt_trap;
    test_reset_mid_mem;
    test_retired_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control sequencer for the single-issue Processor datapath. Walks each instruction through fetch, decode, execute, memory and writeback states, driving the instruction-memory handshake, register-file read/write enables, ALU enable and data-memory handshake. It owns the PC and the instruction register, so the datapath no longer needs a hand-driven instruction register. It sits between instruction/data memory and the existing register file and ALU.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction and data word width

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  leave IDLE and begin execution at boot_addr
- boot_addr  in  ADDR_WIDTH  first fetch address
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_WIDTH  fetch address (= PC)
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  DATA_WIDTH  fetched word
- instruction  out  DATA_WIDTH  latched instruction register
- regfile_read_en  out  1  read both source registers
- regfile_write_en  out  1  write rd
- alu_en  out  1  ALU evaluates this cycle
- branch_taken  in  1  ALU branch compare result, sampled in EXECUTE
- branch_target  in  ADDR_WIDTH  taken-branch PC, sampled in EXECUTE
- dmem_req  out  1  data access request
- dmem_we  out  1  store (1) or load (0)
- dmem_ready  in  1  data access complete
- pc  out  ADDR_WIDTH  current PC
- halted  out  1  HALT opcode executed
- trap  out  1  illegal opcode seen
- retired  out  32  completed-instruction count

## Operation
- Opcode is instruction[6:0]; rd is instruction[11:7].
- Opcode classes: REG 7'b0110011, IMM 7'b0010011, LOAD 7'b0000011, STORE 7'b0100011, BRANCH 7'b1100011, HALT 7'b1111111. Every other opcode is illegal.
- IDLE: all strobes low. When start=1: pc<=boot_addr, go to FETCH. start is ignored in every other state.
- FETCH: imem_req=1 and imem_addr=pc, held until imem_ready. On ready: instruction<=imem_rdata, go to DECODE.
- DECODE: regfile_read_en=1 for one cycle.
  - illegal opcode → TRAP
  - HALT → HALT
  - otherwise → EXECUTE
- EXECUTE: alu_en=1 for one cycle.
  - REG/IMM → WRITEBACK
  - LOAD/STORE → MEM
  - BRANCH → FETCH. pc<=branch_target if branch_taken, else pc+4. retired increments.
- MEM: dmem_req=1, with dmem_we=1 for STORE, held until dmem_ready.
  - LOAD → WRITEBACK
  - STORE → FETCH with pc<=pc+4; retired increments.
- WRITEBACK: regfile_write_en=1 for one cycle, suppressed when rd==0. pc<=pc+4, retired increments, go to FETCH.
- HALT: halted=1; TRAP: trap=1. Both hold until reset. pc and instruction freeze.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_WIDTH.
  - retired wraps from 2^32-1 to 0.
  - HALT and trapping instructions do not count toward retired.

## Timing
- Reset: state IDLE. pc, instruction and retired = 0. Every strobe, halted and trap = 0.
- Reset overrides everything in the same edge, including mid-FETCH or mid-MEM. A pending memory request drops the cycle after reset is asserted.
- Strobes are Moore outputs decoded from the registered state; there is no combinational path from inputs to outputs.
- imem_ready or dmem_ready may be high in the first request cycle (zero wait).
- Each wait cycle adds exactly one cycle of latency.
- Latencies with zero-wait memory:
  - REG/IMM: 4 cycles FETCH→FETCH
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- Ready asserted outside its request state is ignored.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams
  - the state enum (IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP)
  - the ADDR_WIDTH/DATA_WIDTH defaults
- One sub-module, opcode_decoder: combinational, instruction → class one-hot plus illegal flag. The FSM, PC, IR and counter stay in the top.

## Test plan
- Reset, then start with boot_addr=0x100 and REG instruction 0x00208233 (rd=4), zero-wait memory:
  - regfile_write_en high in cycle 4
  - pc=0x104
  - retired=1
- Same instruction with imem_ready delayed 3 cycles: imem_req held 4 cycles, instruction latched only on ready, total 7 cycles.
- LOAD with rd=0 then STORE, dmem_ready delayed 2 cycles:
  - no regfile_write_en for the load
  - dmem_we=1 only during the STORE MEM
  - retired=2, pc=boot+8
- BRANCH at 0x200: with branch_taken=1 and branch_target=0x040, the next imem_addr is 0x040. With branch_taken=0, the next imem_addr is 0x204.
- Opcode 7'h7F → halted=1. Opcode 7'h00 → trap=1. Both are sticky across 20 cycles with strobes low, and retired is unchanged.
- Reset asserted during a MEM wait: the next cycle shows IDLE outputs, and start restarts cleanly at boot_addr. Also preload retired=0xFFFFFFFF via force and retire one instruction: retired wraps to 0.
